sram_stream_reader: RTL and testbench



---
 rtl/sram_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sram_stream_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_reader.sv
// sram_stream_reader
// Read-side initiator for the tensorcore data SRAM. Issues back-to-back reads
// on one SRAM port, tracks the fixed read latency with a shift register of
// issue flags, and buffers returning words in a small FIFO. An output register
// presents the words in address order on a valid/ready stream.
//
// Every issued read owns one FIFO slot from the cycle it is presented to the
// SRAM until it leaves the FIFO for the output register. This credit rule lets
// the FIFO absorb every in-flight word without ever overflowing, whatever the
// downstream stalls.
//
// Optional feature: define SRAM_RD_ABORT_EN to add the abort port. With it,
// abort in ISSUE or DRAIN flushes the transfer and ends it with a done pulse.
// Without it, transfers always run to completion.

module sram_stream_reader #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef SRAM_RD_ABORT_EN
    ,
    input  logic              abort
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]            state;
    logic [ADDR_W:0]       len_q;
    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W:0]       issue_cnt;
    logic [ADDR_W:0]       load_cnt;

    // Issue flags; stage k is set k cycles after the read was presented.
    logic [READ_LATENCY:0] track;
    logic [4:0]            inflight;

    logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [4:0]            fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;

    logic [5:0]            credit_used;
    logic                  credit_ok;
    logic                  start_go;
    logic                  first_go;
    logic                  more_go;
    logic                  issue_go;
    logic                  last_hs;
    logic                  abort_hit;

    // ------------------------------------------------------------------
    // Abort qualification
    // ------------------------------------------------------------------
`ifdef SRAM_RD_ABORT_EN
    assign abort_hit = abort && ((state == S_ISSUE) || (state == S_DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Status and fixed outputs
    // ------------------------------------------------------------------
    assign busy    = (state == S_ISSUE) || (state == S_DRAIN);
    assign done    = (state == S_DONE);
    assign sram_we = 1'b0;

    // ------------------------------------------------------------------
    // Credit accounting and issue decision
    // ------------------------------------------------------------------

    // Count the reads still travelling through the SRAM pipeline.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave it holding its old value and infer a latch.
        inflight = '0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            inflight = inflight + {4'b0000, track[i]};
        end
    end

    // A word leaving the FIFO this cycle frees its slot for a read issued in
    // the same cycle, which keeps the stream bubble-free at full rate.
    assign fifo_pop    = (fifo_count != '0) && (!m_valid || m_ready) && !abort_hit;
    assign fifo_push   = track[READ_LATENCY] && !abort_hit;
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count} - {5'b00000, fifo_pop};
    assign credit_ok   = credit_used < 6'(FIFO_DEPTH);

    // The first read is launched straight from IDLE so it reaches the SRAM in
    // the cycle after start; an idle block always has every credit free.
    assign start_go = (state == S_IDLE) && start;
    assign first_go = start_go && (len != '0);
    assign more_go  = (state == S_ISSUE) && !abort_hit && (issue_cnt < len_q) && credit_ok;
    assign issue_go = first_go || more_go;

    assign last_hs  = m_valid && m_ready && m_last;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // Sequence IDLE -> ISSUE -> DRAIN -> DONE and latch the transfer request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state  <= S_IDLE;
            len_q  <= '0;
            base_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        base_q <= base_addr;
                        // An empty transfer passes through DRAIN, which is
                        // already complete, so busy shows for one cycle.
                        state  <= (len == '0) ? S_DRAIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort_hit) begin
                        state <= S_DONE;
                    end else if (issue_cnt == len_q) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort_hit || (len_q == '0) || last_hs) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // SRAM request port
    // ------------------------------------------------------------------

    // Present one read per granted credit; the address wraps at 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_en   <= 1'b0;
            sram_addr <= '0;
            issue_cnt <= '0;
        end else begin
            sram_en <= issue_go;
            if (start_go) begin
                issue_cnt <= first_go ? CNT_ONE : '0;
                if (first_go) begin
                    sram_addr <= base_addr;
                end
            end else if (more_go) begin
                issue_cnt <= issue_cnt + CNT_ONE;
                sram_addr <= base_q + issue_cnt[ADDR_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracker
    // ------------------------------------------------------------------

    // Shift issue flags so the last stage lines up with valid read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            track <= '0;
        end else if (abort_hit) begin
            track <= '0;
        end else begin
            track <= {track[READ_LATENCY-1:0], issue_go};
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------

    // Capture returning read data; sram_rdata is stale in every other cycle.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers and count decide
        // which entries are meaningful, so clearing the data buys nothing.
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= sram_rdata;
        end
    end

    // Maintain FIFO pointers and occupancy; simultaneous push and pop cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort_hit) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stream output register
    // ------------------------------------------------------------------

    // Load the next word when the output slot is empty or being accepted, and
    // flag the word that completes the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            load_cnt <= '0;
        end else if (abort_hit) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (start_go) begin
            load_cnt <= '0;
        end else if (fifo_pop) begin
            m_valid  <= 1'b1;
            m_data   <= fifo_mem[rd_ptr];
            m_last   <= (load_cnt + CNT_ONE) == len_q;
            load_cnt <= load_cnt + CNT_ONE;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader. A behavioural SRAM with a
// memory stage and an output stage is preloaded with mem[i] = 3*i. Directed
// transfers are checked cycle by cycle against a table and against the
// expected word sequence computed from the preload rule.

module tb_sram_stream_reader;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int RL     = 2;
    localparam int FD     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_rdata;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              abort;

    int errors = 0;
    int checks = 0;

    sram_stream_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .READ_LATENCY(RL),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .sram_en(sram_en),
        .sram_we(sram_we),
        .sram_addr(sram_addr),
        .sram_rdata(sram_rdata),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last)
`ifdef SRAM_RD_ABORT_EN
        ,
        .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: address sampled into the memory stage, then an output stage.
    logic [DATA_W-1:0] mem [0:8191];
    logic [DATA_W-1:0] sram_stage;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'(i * 3);
    end

    always @(posedge clk) begin
        if (sram_en) sram_stage <= mem[sram_addr];
        sram_rdata <= sram_stage;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int b, input int i);
        return 32'(((b + i) % 8192) * 3);
    endfunction

    function automatic logic ready_at(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    // Results of the most recent run_xfer.
    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] data_q[$];
    logic              last_q[$];
    int                xfer_max_out;

    // Launch a transfer and record addresses, delivered words and m_last flags
    // until done is seen or the cycle budget runs out.
    task automatic run_xfer(input string tag, input int b, input int n, input int mode, input int budget);
        int issued    = 0;
        int delivered = 0;
        bit got_done  = 0;
        addr_q.delete();
        data_q.delete();
        last_q.delete();
        xfer_max_out = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        len       = (ADDR_W+1)'(n);
        m_ready   = ready_at(mode, 0);
        for (int c = 0; c < budget && !got_done; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start   = 1'b0;
                m_ready = ready_at(mode, c);
            end
            @(negedge clk);
            if (sram_en) begin
                issued++;
                addr_q.push_back(sram_addr);
            end
            if (issued - delivered > xfer_max_out) xfer_max_out = issued - delivered;
            if (m_valid && m_ready) begin
                delivered++;
                data_q.push_back(m_data);
                last_q.push_back(m_last);
            end
            if (done) got_done = 1;
        end
        start = 1'b0;
        check({tag, " done seen"}, 32'(got_done), 32'd1);
    endtask

    // Compare the recorded stream with the expected words and a single final m_last.
    task automatic verify_words(input string tag, input int b, input int n);
        int nlast = 0;
        check({tag, " word count"}, 32'(data_q.size()), 32'(n));
        for (int i = 0; i < data_q.size(); i++) begin
            if (i < n) check($sformatf("%s word %0d", tag, i), data_q[i], word_at(b, i));
            if (last_q[i]) nlast++;
        end
        check({tag, " m_last count"}, 32'(nlast), 32'd1);
        if (data_q.size() == n && n > 0) check({tag, " m_last position"}, 32'(last_q[n-1]), 32'd1);
    endtask

    typedef struct {
        logic              busy;
        logic              done;
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic              mv;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle-by-cycle expectations for base=100, len=4, m_ready=1; cycle 0 carries start.
        tbl[0]  = '{0, 0, 0, 0,   0, 0,   0};
        tbl[1]  = '{1, 0, 1, 100, 0, 0,   0};
        tbl[2]  = '{1, 0, 1, 101, 0, 0,   0};
        tbl[3]  = '{1, 0, 1, 102, 0, 0,   0};
        tbl[4]  = '{1, 0, 1, 103, 0, 0,   0};
        tbl[5]  = '{1, 0, 0, 0,   1, 300, 0};
        tbl[6]  = '{1, 0, 0, 0,   1, 303, 0};
        tbl[7]  = '{1, 0, 0, 0,   1, 306, 0};
        tbl[8]  = '{1, 0, 0, 0,   1, 309, 1};
        tbl[9]  = '{0, 1, 0, 0,   0, 0,   0};
        tbl[10] = '{0, 0, 0, 0,   0, 0,   0};

        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1; abort = 1'b0;
        #12;
        check("reset busy",      32'(busy),      32'd0);
        check("reset done",      32'(done),      32'd0);
        check("reset sram_en",   32'(sram_en),   32'd0);
        check("reset sram_we",   32'(sram_we),   32'd0);
        check("reset sram_addr", 32'(sram_addr), 32'd0);
        check("reset m_valid",   32'(m_valid),   32'd0);
        check("reset m_data",    m_data,         32'd0);
        check("reset m_last",    32'(m_last),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven basic transfer.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 13'd100; len = 14'd4; m_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            check($sformatf("t1 c%0d busy", c),    32'(busy),    32'(tbl[c].busy));
            check($sformatf("t1 c%0d done", c),    32'(done),    32'(tbl[c].done));
            check($sformatf("t1 c%0d sram_en", c), 32'(sram_en), 32'(tbl[c].en));
            check($sformatf("t1 c%0d m_valid", c), 32'(m_valid), 32'(tbl[c].mv));
            check($sformatf("t1 c%0d m_last", c),  32'(m_last),  32'(tbl[c].last));
            if (tbl[c].en) check($sformatf("t1 c%0d sram_addr", c), 32'(sram_addr), 32'(tbl[c].addr));
            if (tbl[c].mv) check($sformatf("t1 c%0d m_data", c),    m_data,          tbl[c].data);
        end

        // Address wrap at the top of the SRAM.
        run_xfer("wrap", 8190, 4, 0, 60);
        check("wrap addr count", 32'(addr_q.size()), 32'd4);
        if (addr_q.size() == 4) begin
            check("wrap addr 0", 32'(addr_q[0]), 32'd8190);
            check("wrap addr 1", 32'(addr_q[1]), 32'd8191);
            check("wrap addr 2", 32'(addr_q[2]), 32'd0);
            check("wrap addr 3", 32'(addr_q[3]), 32'd1);
        end
        verify_words("wrap", 8190, 4);

        // Backpressure: m_ready toggles 1,0,0,1.
        run_xfer("stall", 500, 16, 1, 400);
        verify_words("stall", 500, 16);
        check("stall issued reads", 32'(addr_q.size()), 32'd16);
        check("stall outstanding bound", 32'(xfer_max_out <= FD + 1), 32'd1);

        // Full-rate run also keeps within the credit bound.
        run_xfer("fullrate", 4000, 12, 0, 100);
        verify_words("fullrate", 4000, 12);
        check("fullrate outstanding bound", 32'(xfer_max_out <= FD + 1), 32'd1);

        // len = 0: one busy cycle, one done cycle, starts while busy/done ignored.
        begin
            int en_seen = 0;
            @(posedge clk); #1;
            start = 1'b1; base_addr = 13'd7; len = 14'd0;
            @(negedge clk);
            if (sram_en) en_seen++;
            @(posedge clk); #1;                // cycle 1, start held high
            @(negedge clk);
            if (sram_en) en_seen++;
            check("len0 c1 busy", 32'(busy), 32'd1);
            check("len0 c1 done", 32'(done), 32'd0);
            @(posedge clk); #1;                // cycle 2, start still high
            @(negedge clk);
            if (sram_en) en_seen++;
            check("len0 c2 busy", 32'(busy), 32'd0);
            check("len0 c2 done", 32'(done), 32'd1);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (sram_en) en_seen++;
            check("len0 c3 busy", 32'(busy), 32'd0);
            check("len0 c3 done", 32'(done), 32'd0);
            check("len0 no sram_en", 32'(en_seen), 32'd0);
        end

        // Reset in the middle of an 8-word transfer, during word 3.
        begin
            int dn = 0;
            @(posedge clk); #1;
            start = 1'b1; base_addr = 13'd1000; len = 14'd8; m_ready = 1'b1;
            for (int c = 1; c <= 7; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            check("rst word3 data", m_data, word_at(1000, 2));
            #2 rst = 1'b1;
            #1;
            check("rst async busy",      32'(busy),      32'd0);
            check("rst async done",      32'(done),      32'd0);
            check("rst async sram_en",   32'(sram_en),   32'd0);
            check("rst async sram_addr", 32'(sram_addr), 32'd0);
            check("rst async m_valid",   32'(m_valid),   32'd0);
            check("rst async m_data",    m_data,         32'd0);
            check("rst async m_last",    32'(m_last),    32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (done || m_valid || busy) dn++;
                @(posedge clk); #1;
            end
            check("rst quiet afterwards", 32'(dn), 32'd0);
            run_xfer("after rst", 2000, 2, 0, 40);
            verify_words("after rst", 2000, 2);
        end

`ifdef SRAM_RD_ABORT_EN
        // Abort while the second of ten words is on the stream.
        begin
            int nlast = 0;
            @(posedge clk); #1;
            start = 1'b1; base_addr = 13'd300; len = 14'd10; m_ready = 1'b1;
            @(negedge clk);
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (c == 6) abort = 1'b1;
                @(negedge clk);
                if (m_last) nlast++;
            end
            check("abort c6 data", m_data, word_at(300, 1));
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            if (m_last) nlast++;
            check("abort c7 m_valid", 32'(m_valid), 32'd0);
            check("abort c7 sram_en", 32'(sram_en), 32'd0);
            check("abort c7 done",    32'(done),    32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            if (m_last) nlast++;
            check("abort c8 done",    32'(done),    32'd0);
            check("abort c8 busy",    32'(busy),    32'd0);
            check("abort no m_last",  32'(nlast),   32'd0);
            run_xfer("after abort", 10, 3, 0, 40);
            verify_words("after abort", 10, 3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
